// File: rtl/sample_packer_pkg.sv
// Shared constants for the I/Q sample packer and its word FIFO.
package sample_packer_pkg;
  localparam int   WORD_W     = 32;
  localparam logic MODE_2BIT  = 1'b0;
  localparam logic MODE_4BIT  = 1'b1;
  localparam int   SLOTS_2BIT = 8;
  localparam int   SLOTS_4BIT = 4;
endpackage

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO; a push while full is taken only if a pop frees a slot the same edge.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, rd_q;
  logic [AW:0]      cnt_q;
  logic             do_push, do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == FULL_CNT);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign dout_o  = mem_q[rd_q];

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= din_i;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  end
endmodule

// File: rtl/sample_packer.sv
// Packs 2-bit or 4-bit I/Q samples MSB-first into 32-bit words and queues them for the framer.
module sample_packer
  import sample_packer_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mode,
  input  logic              in_valid,
  input  logic [1:0]        i2,
  input  logic [1:0]        q2,
  input  logic [3:0]        i4,
  input  logic [3:0]        q4,
  output logic [WORD_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  input  logic              clear_overflow,
  output logic              overflow,
  output logic [CNT_W-1:0]  drop_count
);
  logic              cur_mode_q;
  logic [2:0]        slot_q;
  logic [WORD_W-1:0] shreg_q;
  logic              overflow_q;
  logic [CNT_W-1:0]  drop_cnt_q, drop_cnt_d;

  logic              eff_mode, last_slot, push, drop, pop_fire;
  logic              fifo_full, fifo_empty;
  logic [WORD_W-1:0] word_d;

  // The mode input only matters on the first slot; afterwards the latched word mode rules.
  always_comb begin
    eff_mode  = (slot_q == '0) ? mode : cur_mode_q;
    last_slot = (eff_mode == MODE_4BIT) ? (slot_q == 3'(SLOTS_4BIT - 1))
                                        : (slot_q == 3'(SLOTS_2BIT - 1));
    word_d    = (eff_mode == MODE_4BIT) ? {shreg_q[WORD_W-9:0], i4, q4}
                                        : {shreg_q[WORD_W-5:0], i2, q2};
  end

  assign push     = in_valid && last_slot;
  assign pop_fire = out_valid && out_ready;
  assign drop     = push && fifo_full && !pop_fire;

  always_ff @(posedge clk) begin
    if (reset) begin
      cur_mode_q <= MODE_2BIT;
      slot_q     <= '0;
      shreg_q    <= '0;
    end else if (in_valid) begin
      cur_mode_q <= eff_mode;
      slot_q     <= last_slot ? '0 : slot_q + 3'd1;
      shreg_q    <= last_slot ? '0 : word_d;
    end
  end

  // A drop coinciding with a clear restarts the count at one.
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (drop)
      drop_cnt_d = clear_overflow ? CNT_W'(1)
                 : (&drop_cnt_q) ? drop_cnt_q : drop_cnt_q + CNT_W'(1);
    else if (clear_overflow)
      drop_cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      if (drop)                overflow_q <= 1'b1;
      else if (clear_overflow) overflow_q <= 1'b0;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  sync_fifo #(.WIDTH(WORD_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .din_i   (word_d),
    .pop_i   (out_ready),
    .dout_o  (out_data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign out_valid  = !fifo_empty;
  assign overflow   = overflow_q;
  assign drop_count = drop_cnt_q;
endmodule

// File: tb/tb_sample_packer.sv
// Scoreboard bench for sample_packer: sample-list reference model, queue of expected words, decoupled monitor.
module tb_sample_packer;
  localparam int DEPTH = 16;
  localparam int CW    = 16;

  logic          clk = 1'b0;
  logic          reset, mode, in_valid, out_ready, clear_overflow;
  logic [1:0]    i2, q2;
  logic [3:0]    i4, q4;
  logic [31:0]   out_data;
  logic          out_valid, overflow;
  logic [CW-1:0] drop_count;

  sample_packer #(.FIFO_DEPTH(DEPTH), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .mode(mode), .in_valid(in_valid),
    .i2(i2), .q2(q2), .i4(i4), .q4(q4),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .clear_overflow(clear_overflow), .overflow(overflow), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model state
  int            samp[$];
  bit            wmode;
  logic [31:0]   mq[$];
  logic [31:0]   expq[$];
  bit            m_ovf;
  logic [CW-1:0] m_cnt;
  logic [31:0]   last_pop;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] form_word(int s[$], bit m);
    longint w = 0;
    foreach (s[k]) w = w * (m ? 256 : 16) + s[k];
    return w[31:0];
  endfunction

  task automatic model_reset();
    samp.delete(); mq.delete(); expq.delete();
    wmode = 0; m_ovf = 0; m_cnt = '0;
  endtask

  // One clock: compare the state left by the last edge, drive inputs, advance the model across the edge.
  task automatic step(bit v, bit md, logic [7:0] b8, logic [3:0] n4, bit rdy, bit clr);
    bit push, pop;
    logic [31:0] w;
    chk("out_valid", {31'b0, out_valid}, {31'b0, mq.size() != 0});
    chk("overflow", {31'b0, overflow}, {31'b0, m_ovf});
    chk("drop_count", {16'b0, drop_count}, {16'b0, m_cnt});
    in_valid = v; mode = md; i4 = b8[7:4]; q4 = b8[3:0];
    i2 = n4[3:2]; q2 = n4[1:0]; out_ready = rdy; clear_overflow = clr;
    push = 0; w = '0;
    if (v) begin
      if (samp.size() == 0) wmode = md;
      samp.push_back(wmode ? int'(b8) : int'(n4));
      if (samp.size() == (wmode ? 4 : 8)) begin
        w = form_word(samp, wmode);
        samp.delete();
        push = 1;
      end
    end
    pop = (mq.size() != 0) && rdy;
    if (pop) void'(mq.pop_front());
    if (push && mq.size() < DEPTH) begin
      mq.push_back(w);
      expq.push_back(w);
    end else if (push) begin
      m_ovf = 1;
      m_cnt = clr ? CW'(1) : ((&m_cnt) ? m_cnt : m_cnt + CW'(1));
    end
    if (!(push && !(mq.size() < DEPTH) && !pop) && clr && !(push && mq.size() == DEPTH && !pop)) begin
      if (!(push && !pop && mq.size() >= DEPTH)) begin
        m_ovf = 0; m_cnt = '0;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset = 1; in_valid = 0; out_ready = 0; clear_overflow = 0;
    model_reset();
    @(posedge clk); #1;
    reset = 0;
  endtask

  task automatic idle(int n, bit rdy);
    for (int k = 0; k < n; k++) step(0, 0, 8'h00, 4'h0, rdy, 0);
  endtask

  initial begin
    reset = 1; mode = 0; in_valid = 0; out_ready = 0; clear_overflow = 0;
    i2 = 0; q2 = 0; i4 = 0; q4 = 0; last_pop = '0;
    model_reset();
    fork
      forever begin
        @(negedge clk);
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
          if (expq.size() == 0) begin
            checks++; errors++;
            $display("FAIL pop_unexpected: got %h expected none at %0t", out_data, $time);
          end else begin
            last_pop = out_data;
            chk("out_data", out_data, expq.pop_front());
          end
        end
      end
    join_none
    repeat (2) @(posedge clk); #1;
    do_reset();

    // 2-bit samples 0..7 -> 01234567
    for (int k = 0; k < 8; k++) step(1, 0, 8'($urandom), 4'(k), 1, 0);
    idle(2, 1);
    chk("word_2bit", last_pop, 32'h01234567);

    // 4-bit samples with idle gaps
    step(1, 1, 8'hA1, 4'($urandom), 1, 0); idle(2, 1);
    step(1, 1, 8'hB2, 4'($urandom), 1, 0); idle(1, 1);
    step(1, 1, 8'hC3, 4'($urandom), 1, 0); idle(3, 1);
    step(1, 1, 8'hD4, 4'($urandom), 1, 0); idle(2, 1);
    chk("word_4bit_gaps", last_pop, 32'hA1B2C3D4);

    // mode change after 3 samples lands at the next word boundary
    for (int k = 0; k < 8; k++) step(1, k >= 3, 8'($urandom), 4'(k + 1), 1, 0);
    idle(2, 1);
    chk("word_mode_hold", last_pop, 32'h12345678);
    for (int k = 0; k < 4; k++) step(1, 1, 8'(8'h11 * (k + 1)), 4'($urandom), 1, 0);
    idle(2, 1);
    chk("word_after_switch", last_pop, 32'h11223344);

    // fill past capacity with the consumer stalled
    for (int w = 0; w < DEPTH + 3; w++)
      for (int k = 0; k < 4; k++) step(1, 1, 8'($urandom), 4'($urandom), 0, 0);
    idle(1, 0);
    chk("ovf_sticky", {31'b0, overflow}, 32'd1);
    chk("drops_3", {16'b0, drop_count}, 32'd3);
    // full FIFO with a pop on the completing edge: no drop
    for (int k = 0; k < 4; k++) step(1, 1, 8'($urandom), 4'($urandom), k == 3, 0);
    idle(1, 0);
    chk("no_drop_on_pop", {16'b0, drop_count}, 32'd3);
    step(0, 0, 8'h00, 4'h0, 0, 1);
    idle(1, 0);
    chk("clear_ovf", {31'b0, overflow}, 32'd0);
    chk("clear_cnt", {16'b0, drop_count}, 32'd0);
    idle(DEPTH + 4, 1);

    // reset mid-word discards the partial word
    for (int k = 0; k < 5; k++) step(1, 0, 8'($urandom), 4'hF, 1, 0);
    do_reset();
    idle(1, 1);
    for (int k = 0; k < 8; k++) step(1, 0, 8'($urandom), 4'(8 + k), 1, 0);
    idle(2, 1);
    chk("word_after_reset", last_pop, 32'h89ABCDEF);

    // randomized traffic, including drops and clears
    for (int c = 0; c < 800; c++)
      step($urandom_range(0, 3) != 0, 1'($urandom), 8'($urandom), 4'($urandom),
           $urandom_range(0, 9) < 4, $urandom_range(0, 40) == 0);
    idle(DEPTH + 4, 1);
    chk("scoreboard_empty", 32'(expq.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/sample_packer.md
# sample_packer

Packs per-clock quantized I/Q samples (2-bit or 4-bit per component, from the quantizer stage) into 32-bit words and buffers them in a small FIFO for the packet/Ethernet framing stage. It sits directly downstream of the quantizer and provides a valid/ready stream interface toward the framer. Overflow is reported by a sticky flag and a saturating drop counter; the quantizer side has no backpressure.

## Interface
- FIFO_DEPTH, 16: word FIFO depth; power of two, ≥4
- CNT_W, 16: drop counter width
- clk  in  1  sample clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- mode  in  1  0 = 2-bit samples, 1 = 4-bit samples
- in_valid  in  1  sample present this cycle
- i2, q2  in  2 each  2-bit I/Q samples (used when mode=0)
- i4, q4  in  4 each  4-bit I/Q samples (used when mode=1)
- out_data  out  32  FIFO head word
- out_valid  out  1  FIFO non-empty
- out_ready  in  1  consumer accepts out_data when out_valid && out_ready
- clear_overflow  in  1  clears overflow and drop_count
- overflow  out  1  sticky: at least one word dropped
- drop_count  out  CNT_W  dropped words, saturates at all-ones

## Operation
- Sample nibble/byte: mode 0 → {i2,q2} (4 bits), 8 samples per word; mode 1 → {i4,q4} (8 bits), 4 samples per word.
- Ordering MSB-first: first sample of a word occupies out_data[31:28] (mode 0) or [31:24] (mode 1).
- Word mode latched when first sample of a word is accepted (cur_mode); mode changes mid-word take effect at next word boundary; partial word is never discarded or reformatted.
- Sample counter slot: 0..7 (mode 0) or 0..3 (mode 1); increments per in_valid cycle, wraps to 0 on completing a word.
- Word completion: the accepted sample filling the last slot forms the full word (shift register contents plus that sample) and is pushed into the FIFO at that same edge.
- Push when FIFO full and no pop this cycle: word dropped, overflow←1, drop_count+1 (saturating). Full with simultaneous pop: push accepted, no drop.
- Pop: out_valid && out_ready removes head at the edge.
- clear_overflow: overflow←0, drop_count←0; if a drop occurs in the same cycle, the drop wins (overflow=1, drop_count=1).
- in_valid low: state holds; no gap filling.
- Reset values: out_valid=0, overflow=0, drop_count=0, slot=0, FIFO empty, shift register 0, cur_mode=0. out_data is don't-care while out_valid=0. A partial word at reset is discarded.

## Timing
- Last sample of a word accepted at edge E → word is in FIFO after E; out_valid=1 in the following cycle if the FIFO was empty (1-cycle latency).
- FIFO is show-ahead: out_data is stable and valid whenever out_valid=1, held until popped.
- Sustained throughput: 1 push per 8 (mode 0) or 4 (mode 1) valid cycles; the consumer must sustain that rate to avoid drops.
- overflow and drop_count update at the edge of the dropped push.

## Structure
- Shared package: WORD_W=32, MODE_2BIT=0, MODE_4BIT=1, slots-per-word constants (8, 4).
- One sub-module, sync_fifo: single-clock, show-ahead FIFO with width and depth parameters, full/empty outputs, simultaneous push/pop when full.
- Packer (shift register, slot counter, cur_mode) and overflow accounting live in sample_packer.

## Test plan
- Mode 0, out_ready=1, 8 consecutive samples {i2,q2}=0x0..0x7 → one word 32'h01234567, out_valid one cycle after the 8th sample.
- Mode 1, samples {i4,q4}=A1,B2,C3,D4 with in_valid gaps between them → 32'hA1B2C3D4; gaps do not change content.
- Mode switched 0→1 after 3 samples → current word completes in 2-bit format (8 samples); the next word is packed in 4-bit format.
- out_ready=0, push FIFO_DEPTH+3 words → first 16 retained in order, overflow=1, drop_count=3; clear_overflow → 0, 0.
- FIFO full, out_ready=1 on the cycle a new word completes → no drop, occupancy stays at FIFO_DEPTH.
- reset asserted after 5 samples of a word → out_valid=0; the next 8 samples form a clean word with no residue from before reset.
